control_sequencer: RTL

//  Hardwired control unit for the single-bus DataPath. Steps T0..T5 of fetch/execute and drives every

---
 rtl/cpu_ctrl_pkg.sv | 69 ++++++
 rtl/ctrl_decode.sv | 79 +++++++
 rtl/control_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding, opcodes,
// IR field positions and the strobe bundle driven onto the single-bus datapath.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StT0    = 4'd1,
        StT1    = 4'd2,
        StT1w   = 4'd3,
        StT2    = 4'd4,
        StT3    = 4'd5,
        StT4    = 4'd6,
        StT5    = 4'd7,
        StHalt  = 4'd8,
        StFault = 4'd9
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int unsigned IR_OP_MSB = 31;
    localparam int unsigned IR_RA_MSB = 26;
    localparam int unsigned IR_RB_MSB = 22;
    localparam int unsigned IR_RC_MSB = 18;

    typedef enum logic [1:0] {
        OpcBinary,
        OpcUnary,
        OpcHalt,
        OpcIllegal
    } op_class_e;

    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic r_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic r_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic grc;
        logic busy;
        logic halted;
        logic fault;
    } ctrl_strobes_t;

    function automatic op_class_e classify_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: return OpcBinary;
            OP_NEG, OP_NOT:                return OpcUnary;
            OP_HALT:                       return OpcHalt;
            default:                       return OpcIllegal;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: maps the sequencer state and current opcode onto the
// datapath control strobes and ALU function.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  state_e         state,
    input  logic [OPW-1:0] op,
    output ctrl_strobes_t  strobes,
    output logic [OPW-1:0] alu_op
);

    op_class_e op_class;
    assign op_class = classify_op(5'(op));

    always_comb begin
        strobes = '0;
        alu_op  = '0;
        unique case (state)
            StIdle: ;
            StT0: begin
                strobes.pc_out  = 1'b1;
                strobes.mar_in  = 1'b1;
                strobes.inc_pc  = 1'b1;
                strobes.zlow_in = 1'b1;
                strobes.busy    = 1'b1;
            end
            StT1: begin
                strobes.zlow_out = 1'b1;
                strobes.pc_in    = 1'b1;
                strobes.read     = 1'b1;
                strobes.mdr_in   = 1'b1;
                strobes.busy     = 1'b1;
            end
            // PC already loaded in T1; only keep the MDR load pending.
            StT1w: begin
                strobes.read   = 1'b1;
                strobes.mdr_in = 1'b1;
                strobes.busy   = 1'b1;
            end
            StT2: begin
                strobes.mdr_out = 1'b1;
                strobes.ir_in   = 1'b1;
                strobes.busy    = 1'b1;
            end
            StT3: begin
                strobes.busy = 1'b1;
                if (op_class == OpcBinary) begin
                    strobes.grb   = 1'b1;
                    strobes.r_out = 1'b1;
                    strobes.y_in  = 1'b1;
                end else if (op_class == OpcUnary) begin
                    strobes.grb     = 1'b1;
                    strobes.r_out   = 1'b1;
                    strobes.zlow_in = 1'b1;
                    alu_op          = op;
                end
            end
            StT4: begin
                strobes.grc     = 1'b1;
                strobes.r_out   = 1'b1;
                strobes.zlow_in = 1'b1;
                strobes.busy    = 1'b1;
                alu_op          = op;
            end
            StT5: begin
                strobes.zlow_out = 1'b1;
                strobes.gra      = 1'b1;
                strobes.r_in     = 1'b1;
                strobes.busy     = 1'b1;
            end
            StHalt:  strobes.halted = 1'b1;
            StFault: strobes.fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer (T0..T5) for the single-bus datapath, with a bounded
// wait on memory ready during instruction fetch.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW         = 5,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           run,
    input  logic           mem_rdy,
    input  logic [31:0]    IR,
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           Rout,
    output logic           MARin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zlowin,
    output logic           Rin,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic [OPW-1:0] alu_op,
    output logic           busy,
    output logic           halted,
    output logic           fault
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    state_e         state_q;
    logic [OPW-1:0] op_q;
    logic [CntW-1:0] wait_cnt_q;
    logic [OPW-1:0] ir_op;
    logic [OPW-1:0] dec_op;
    ctrl_strobes_t  strobes;
    logic           unused_ir;

    assign ir_op     = IR[IR_OP_MSB -: OPW];
    assign unused_ir = ^IR[IR_OP_MSB-OPW:0];

    // IR is loaded at the end of T2, so T3 decodes the live IR; later states use the copy.
    assign dec_op = (state_q == StT3) ? ir_op : op_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= StIdle;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: if (run) state_q <= StT0;
                StT0:   state_q <= StT1;
                StT1: begin
                    if (mem_rdy) begin
                        state_q <= StT2;
                    end else begin
                        state_q    <= StT1w;
                        wait_cnt_q <= CntW'(1);
                    end
                end
                // Ready on the final permitted wait cycle still completes the fetch.
                StT1w: begin
                    if (mem_rdy)                             state_q <= StT2;
                    else if (wait_cnt_q == CntW'(MEM_TIMEOUT)) state_q <= StFault;
                    else                                     wait_cnt_q <= wait_cnt_q + CntW'(1);
                end
                StT2: state_q <= StT3;
                StT3: begin
                    op_q <= ir_op;
                    case (classify_op(5'(ir_op)))
                        OpcBinary: state_q <= StT4;
                        OpcUnary:  state_q <= StT5;
                        OpcHalt:   state_q <= StHalt;
                        default:   state_q <= StFault;
                    endcase
                end
                StT4:    state_q <= StT5;
                StT5:    state_q <= run ? StT0 : StIdle;
                StHalt:  state_q <= StHalt;
                StFault: state_q <= StFault;
                default: state_q <= StFault;
            endcase
        end
    end

    ctrl_decode #(
        .OPW(OPW)
    ) u_decode (
        .state  (state_q),
        .op     (dec_op),
        .strobes(strobes),
        .alu_op (alu_op)
    );

    assign PCout   = strobes.pc_out;
    assign Zlowout = strobes.zlow_out;
    assign MDRout  = strobes.mdr_out;
    assign Rout    = strobes.r_out;
    assign MARin   = strobes.mar_in;
    assign PCin    = strobes.pc_in;
    assign MDRin   = strobes.mdr_in;
    assign IRin    = strobes.ir_in;
    assign Yin     = strobes.y_in;
    assign Zlowin  = strobes.zlow_in;
    assign Rin     = strobes.r_in;
    assign IncPC   = strobes.inc_pc;
    assign Read    = strobes.read;
    assign Gra     = strobes.gra;
    assign Grb     = strobes.grb;
    assign Grc     = strobes.grc;
    assign busy    = strobes.busy;
    assign halted  = strobes.halted;
    assign fault   = strobes.fault;

endmodule
